// File: rtl/vga_rx_monitor.sv
// VGA receive-side checker: timing measurement, lock tracking and pixel capture.
// Optional per-frame checksum enabled by defining VGA_RX_CHECKSUM_EN.
module vga_rx_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int TIMEOUT  = 256
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic        VGA_SYNC_N,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  output logic        pix_we,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_done,
  output logic        locked,
  output logic [11:0] meas_h_total,
  output logic [11:0] meas_h_active,
  output logic [11:0] meas_v_total,
  output logic [11:0] meas_v_active,
  output logic        err_h,
  output logic        err_v,
  output logic [15:0] frame_sum
);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  logic sync_unused;
  assign sync_unused = VGA_SYNC_N;

  logic        clk_s1, clk_s2;
  logic        hs_s1, vs_s1, blank_s1;
  logic [23:0] rgb_s1;
  logic        pe;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      hs_s1    <= 1'b0;
      vs_s1    <= 1'b0;
      blank_s1 <= 1'b0;
      rgb_s1   <= '0;
    end else begin
      clk_s1   <= VGA_CLK;
      clk_s2   <= clk_s1;
      hs_s1    <= VGA_HS;
      vs_s1    <= VGA_VS;
      blank_s1 <= VGA_BLANK_N;
      rgb_s1   <= {VGA_R, VGA_G, VGA_B};
    end
  end

  assign pe = clk_s1 & ~clk_s2;

  // Event stage: sync edges are judged pixel-to-pixel, not clock-to-clock.
  logic        hs_last, vs_last;
  logic        ev_d, hs_fall_d, vs_fall_d, blank_d;
  logic [23:0] rgb_d;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hs_last   <= 1'b0;
      vs_last   <= 1'b0;
      ev_d      <= 1'b0;
      hs_fall_d <= 1'b0;
      vs_fall_d <= 1'b0;
      blank_d   <= 1'b0;
      rgb_d     <= '0;
    end else begin
      ev_d      <= pe;
      hs_fall_d <= pe & hs_last & ~hs_s1;
      vs_fall_d <= pe & vs_last & ~vs_s1;
      blank_d   <= blank_s1;
      rgb_d     <= rgb_s1;
      if (pe) begin
        hs_last <= hs_s1;
        vs_last <= vs_s1;
      end
    end
  end

  state_t      state, state_n;
  logic [11:0] h_cnt, act_cnt, line_act, v_cnt;
  logic [11:0] h_cnt_n, act_cnt_n, line_act_n, v_cnt_n;
  logic [11:0] mht_n, mha_n, mvt_n, mva_n;
  logic [TW-1:0] to_cnt;
  logic        timeout, wr, fd, match;

  assign timeout = (to_cnt >= TW'(TIMEOUT));

  always_comb begin
    h_cnt_n    = h_cnt;
    act_cnt_n  = act_cnt;
    line_act_n = line_act;
    v_cnt_n    = v_cnt;
    mht_n      = meas_h_total;
    mha_n      = meas_h_active;
    mvt_n      = meas_v_total;
    mva_n      = meas_v_active;
    if (ev_d) begin
      h_cnt_n = hs_fall_d ? 12'd0 : sat_inc(h_cnt);
      if (blank_d)
        act_cnt_n = sat_inc(act_cnt);
      if (hs_fall_d) begin
        mht_n = sat_inc(h_cnt);
        if (act_cnt != 12'd0) begin
          mha_n      = act_cnt;
          line_act_n = sat_inc(line_act);
        end
        v_cnt_n   = sat_inc(v_cnt);
        act_cnt_n = 12'd0;
      end
      // Line update above lands first so a shared HS/VS pixel is counted.
      if (vs_fall_d) begin
        mvt_n      = v_cnt_n;
        mva_n      = line_act_n;
        v_cnt_n    = 12'd0;
        line_act_n = 12'd0;
      end
    end
  end

  assign wr = ev_d & blank_d & (state != SEARCH)
            & (act_cnt < 12'(H_ACTIVE))
            & (line_act < 12'(V_ACTIVE));
  assign fd = ev_d & vs_fall_d & (state != SEARCH);
  assign match = (mht_n == 12'(H_TOTAL)) & (mha_n == 12'(H_ACTIVE))
               & (mvt_n == 12'(V_TOTAL)) & (mva_n == 12'(V_ACTIVE));

  always_comb begin
    state_n = state;
    if (timeout) begin
      state_n = SEARCH;
    end else if (ev_d && vs_fall_d) begin
      unique case (state)
        SEARCH:  state_n = ACQUIRE;
        ACQUIRE: state_n = match ? LOCKED : ACQUIRE;
        LOCKED:  state_n = match ? LOCKED : ACQUIRE;
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= SEARCH;
      to_cnt        <= '0;
      h_cnt         <= '0;
      act_cnt       <= '0;
      line_act      <= '0;
      v_cnt         <= '0;
      meas_h_total  <= '0;
      meas_h_active <= '0;
      meas_v_total  <= '0;
      meas_v_active <= '0;
      pix_we        <= 1'b0;
      pix_x         <= '0;
      pix_y         <= '0;
      pix_rgb       <= '0;
      frame_done    <= 1'b0;
      locked        <= 1'b0;
      err_h         <= 1'b0;
      err_v         <= 1'b0;
    end else begin
      state         <= state_n;
      to_cnt        <= ev_d ? '0 : (timeout ? to_cnt : to_cnt + 1'b1);
      h_cnt         <= h_cnt_n;
      act_cnt       <= act_cnt_n;
      line_act      <= line_act_n;
      v_cnt         <= v_cnt_n;
      meas_h_total  <= mht_n;
      meas_h_active <= mha_n;
      meas_v_total  <= mvt_n;
      meas_v_active <= mva_n;
      pix_we        <= wr;
      frame_done    <= fd;
      locked        <= (state_n == LOCKED);
      if (wr) begin
        pix_x   <= act_cnt[9:0];
        pix_y   <= line_act[9:0];
        pix_rgb <= rgb_d;
      end
      if (fd) begin
        err_h <= (mht_n != 12'(H_TOTAL)) | (mha_n != 12'(H_ACTIVE));
        err_v <= (mvt_n != 12'(V_TOTAL)) | (mva_n != 12'(V_ACTIVE));
      end
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc, acc_n, rgb_sum;

  assign rgb_sum = 16'(rgb_d[23:16]) + 16'(rgb_d[15:8]) + 16'(rgb_d[7:0]);
  assign acc_n   = acc + (wr ? rgb_sum : 16'd0);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      acc       <= '0;
      frame_sum <= '0;
    end else if (fd) begin
      acc       <= '0;
      frame_sum <= acc_n;
    end else begin
      acc <= acc_n;
    end
  end
`else
  assign frame_sum = 16'd0;
`endif

endmodule
